// File: rtl/dht_reader_ctrl_pkg.sv
// Shared types and helpers for the DHT11/DHT22 single-wire reader.
package dht_reader_ctrl_pkg;

    localparam int FRAME_BITS = 40;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK,
        ST_COOLDOWN
    } state_t;

    typedef enum logic [2:0] {
        ERR_OK        = 3'd0,
        ERR_NO_RESP   = 3'd1,
        ERR_RESP_LOW  = 3'd2,
        ERR_RESP_HIGH = 3'd3,
        ERR_BIT       = 3'd4,
        ERR_CHECKSUM  = 3'd5
    } err_t;

    function automatic int us_to_ticks(input int clk_freq_hz, input int us);
        return (clk_freq_hz / 1_000_000) * us;
    endfunction

    // Frame is {hum_int, hum_dec, tmp_int, tmp_dec, checksum}
    function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/dht_reader_ctrl_if.sv
// Command-side handshake and result bus of the DHT reader.
interface dht_reader_ctrl_if;
    logic        start;
    logic        ready;
    logic        busy;
    logic        done;
    logic        valid;
    logic        dir;
    logic [39:0] data_out;
    logic [2:0]  error_code;

    modport master (
        output start,
        input  ready, busy, done, valid, dir, data_out, error_code
    );

    modport slave (
        input  start,
        output ready, busy, done, valid, dir, data_out, error_code
    );
endinterface

// File: rtl/dht_reader_ctrl_in_sync.sv
// Metastability chain for the sensor line; resets to the idle (pulled-up) level.
module dht_reader_ctrl_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '1;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/dht_reader_ctrl.sv
// DHT11/DHT22 reader: start pulse, response handshake, 40-bit capture, checksum, cooldown.
//  state      | meaning
//  IDLE       | line released, waiting for start while ready
//  START_LOW  | host drives line low for START_LOW_US
//  RELEASE    | line released, waiting for sensor to pull low
//  RESP_LOW   | sensor response low phase
//  RESP_HIGH  | sensor response high phase
//  BIT_LOW    | low preamble of a data bit
//  BIT_HIGH   | high time of a data bit, length decides 0/1
//  CHECK      | checksum compare, result latch
//  COOLDOWN   | enforced gap before the next read
module dht_reader_ctrl
    import dht_reader_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_LOW_US  = 18_000,
    parameter int TIMEOUT_US    = 100,
    parameter int BIT1_THR_US   = 40,
    parameter int MIN_PERIOD_MS = 1_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    inout  wire               dht_data,
    dht_reader_ctrl_if.slave  bus
);
    localparam int TICKS_US      = CLK_FREQ_HZ / 1_000_000;
    localparam int START_TICKS   = us_to_ticks(CLK_FREQ_HZ, START_LOW_US);
    localparam int TIMEOUT_TICKS = us_to_ticks(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int THR_TICKS     = us_to_ticks(CLK_FREQ_HZ, BIT1_THR_US);
    localparam int COOL_TICKS    = us_to_ticks(CLK_FREQ_HZ, MIN_PERIOD_MS * 1000);
    // Our own drive-low is still in the sync chain right after release; ignore it.
    localparam int BLANK_TICKS   = SYNC_STAGES + 2 * TICKS_US;
    localparam int MAX_TICKS     = (COOL_TICKS > START_TICKS) ? COOL_TICKS : START_TICKS;
    localparam int CNT_W         = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] START_LIM   = CNT_W'(START_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LIM    = CNT_W'(COOL_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] THR_LIM     = CNT_W'(THR_TICKS);
    localparam logic [CNT_W-1:0] BLANK_LIM   = CNT_W'(BLANK_TICKS);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [5:0]              bit_idx;
    logic [FRAME_BITS-1:0]   shift;
    logic [FRAME_BITS-1:0]   data_out;
    err_t                    error_code;
    logic                    dir, ready, busy, done, valid;
    logic                    line;
    logic                    timed_out, fail;
    err_t                    fail_code;

    dht_reader_ctrl_in_sync #(.STAGES(SYNC_STAGES)) u_in_sync (
        .clk   (clk_50MHz),
        .rst_n (rst),
        .d     (dht_data),
        .q     (line)
    );

    // Open-drain style pad: the host only ever pulls low.
    assign dht_data = dir ? 1'b0 : 1'bz;

    assign timed_out = (cnt >= TIMEOUT_LIM);

    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_OK;
        case (state)
            ST_RELEASE:   if (timed_out && !(!line && cnt >= BLANK_LIM)) begin
                              fail = 1'b1; fail_code = ERR_NO_RESP;
                          end
            ST_RESP_LOW:  if (timed_out && !line) begin fail = 1'b1; fail_code = ERR_RESP_LOW;  end
            ST_RESP_HIGH: if (timed_out &&  line) begin fail = 1'b1; fail_code = ERR_RESP_HIGH; end
            ST_BIT_LOW:   if (timed_out && !line) begin fail = 1'b1; fail_code = ERR_BIT;       end
            ST_BIT_HIGH:  if (timed_out &&  line) begin fail = 1'b1; fail_code = ERR_BIT;       end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            error_code <= ERR_OK;
            dir        <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= cnt + 1'b1;
            if (fail) begin
                state      <= ST_COOLDOWN;
                cnt        <= '0;
                dir        <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                error_code <= fail_code;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (bus.start && ready) begin
                            state      <= ST_START_LOW;
                            ready      <= 1'b0;
                            busy       <= 1'b1;
                            dir        <= 1'b1;
                            valid      <= 1'b0;
                            error_code <= ERR_OK;
                            bit_idx    <= 6'(FRAME_BITS - 1);
                            shift      <= '0;
                        end
                    end
                    ST_START_LOW: if (cnt >= START_LIM) begin
                        state <= ST_RELEASE; cnt <= '0; dir <= 1'b0;
                    end
                    ST_RELEASE: if (!line && cnt >= BLANK_LIM) begin
                        state <= ST_RESP_LOW; cnt <= '0;
                    end
                    ST_RESP_LOW:  if (line)  begin state <= ST_RESP_HIGH; cnt <= '0; end
                    ST_RESP_HIGH: if (!line) begin state <= ST_BIT_LOW;   cnt <= '0; end
                    ST_BIT_LOW:   if (line)  begin state <= ST_BIT_HIGH;  cnt <= '0; end
                    ST_BIT_HIGH: if (!line) begin
                        shift <= {shift[FRAME_BITS-2:0], (cnt > THR_LIM)};
                        cnt   <= '0;
                        if (bit_idx == 6'd0) begin
                            state <= ST_CHECK;
                        end else begin
                            bit_idx <= bit_idx - 6'd1;
                            state   <= ST_BIT_LOW;
                        end
                    end
                    ST_CHECK: begin
                        state <= ST_COOLDOWN;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (checksum_ok(shift)) begin
                            data_out <= shift;
                            valid    <= 1'b1;
                        end else begin
                            error_code <= ERR_CHECKSUM;
                        end
                    end
                    ST_COOLDOWN: if (cnt >= COOL_LIM) begin
                        state <= ST_IDLE; cnt <= '0; ready <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE; cnt <= '0; dir <= 1'b0; busy <= 1'b0; ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.valid      = valid;
    assign bus.dir        = dir;
    assign bus.data_out   = data_out;
    assign bus.error_code = error_code;
endmodule
